// File: rtl/frame_bootloader.sv
// frame_bootloader: UART-fed RAM loader that holds a CPU in reset while a frame is downloaded.
// Frame: 16-bit big-endian word count N, then N*WORD_BYTES data bytes (LSB-first per word),
// then an optional 8-bit modulo-256 checksum byte. Every accepted byte is echoed back.
// Optional feature macro: BOOT_CHECKSUM_EN (adds the checksum byte and its accumulator).
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   rx_data, rx_done            received byte and its 1-cycle valid pulse
//   tx_data, transmit, tx_done  echo byte, 1-cycle send request, 1-cycle echo-complete pulse
//   ram_addr, ram_data, ram_we  RAM word write port (1-cycle strobe)
//   trigger                     start/restart a boot
//   booting, cpu_rst            high while a boot is in progress or has failed
//   done, error                 sticky success / failure flags
module frame_bootloader #(
  parameter int unsigned ADDR_BITS      = 16,
  parameter int unsigned WORD_BYTES     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_done,
  input  logic                    tx_done,
  output logic [7:0]              tx_data,
  output logic                    transmit,
  output logic [ADDR_BITS-1:0]    ram_addr,
  output logic [8*WORD_BYTES-1:0] ram_data,
  output logic                    ram_we,
  input  logic                    trigger,
  output logic                    booting,
  output logic                    cpu_rst,
  output logic                    done,
  output logic                    error
);

  localparam int unsigned DataW = 8 * WORD_BYTES;
  localparam int unsigned IdxW  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);
  // 2^ADDR_BITS words is the largest legal frame; needs 17 bits when ADDR_BITS = 16.
  localparam logic [16:0] MaxWords = 17'(1) << ADDR_BITS;

  typedef enum logic [3:0] {
    StIdle, StHdrHi, StHdrLo, StRecv, StEcho, StWrite, StCksum, StFinish, StFail
  } state_e;

`ifdef BOOT_CHECKSUM_EN
  localparam state_e StAfterData = StCksum;
`else
  localparam state_e StAfterData = StFinish;
`endif

  state_e               state_q, state_d;
  state_e               ret_q, ret_d;     // receive state whose byte is being echoed
  logic [15:0]          n_q, n_d;         // header, then words still to write
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DataW-1:0]     data_q, data_d;
  logic [IdleW-1:0]     idle_q, idle_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 transmit_q, transmit_d;
  logic                 boot_q, boot_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]           sum_q, sum_d;
`endif

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    n_d        = n_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    data_d     = data_q;
    idle_d     = '0;
    tx_data_d  = tx_data_q;
    transmit_d = 1'b0;
    boot_d     = boot_q;
    done_d     = done_q;
    error_d    = error_q;
`ifdef BOOT_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    if (trigger) begin
      state_d = StHdrHi;
      boot_d  = 1'b1;
      done_d  = 1'b0;
      error_d = 1'b0;
      addr_d  = '0;
      idx_d   = '0;
      n_d     = '0;
`ifdef BOOT_CHECKSUM_EN
      sum_d   = '0;
`endif
    end else begin
      unique case (state_q)
        StHdrHi, StHdrLo, StRecv, StCksum: begin
          if (rx_done) begin
            tx_data_d  = rx_data;
            transmit_d = 1'b1;
            ret_d      = state_q;
            state_d    = StEcho;
            unique case (state_q)
              StHdrHi: n_d[15:8] = rx_data;
              StHdrLo: n_d[7:0]  = rx_data;
              StRecv: begin
                data_d[8*idx_q +: 8] = rx_data;
                idx_d = (idx_q == IdxW'(WORD_BYTES - 1)) ? '0 : idx_q + IdxW'(1);
`ifdef BOOT_CHECKSUM_EN
                sum_d = sum_q + rx_data;
`endif
              end
              default: ;
            endcase
          end else if (idle_q == IdleW'(TIMEOUT_CYCLES - 1)) begin
            state_d = StFail;
          end else begin
            idle_d = idle_q + IdleW'(1);
          end
        end
        StEcho: begin
          // rx_done is deliberately not looked at here: bytes arriving mid-echo are dropped.
          if (tx_done) begin
            unique case (ret_q)
              StHdrHi: state_d = StHdrLo;
              StHdrLo: begin
                if ({1'b0, n_q} > MaxWords) state_d = StFail;
                else if (n_q == 16'd0)      state_d = StAfterData;
                else                        state_d = StRecv;
              end
              // Index wraps to 0 exactly when a word has been completed.
              StRecv:  state_d = (idx_q == '0) ? StWrite : StRecv;
`ifdef BOOT_CHECKSUM_EN
              // tx_data_q still holds the checksum byte that was just echoed.
              StCksum: state_d = (tx_data_q == sum_q) ? StFinish : StFail;
`endif
              default: state_d = StFail;
            endcase
          end
        end
        StWrite: begin
          addr_d  = addr_q + ADDR_BITS'(1);
          n_d     = n_q - 16'd1;
          state_d = (n_q == 16'd1) ? StAfterData : StRecv;
        end
        StFinish: begin
          done_d  = 1'b1;
          boot_d  = 1'b0;
          state_d = StIdle;
        end
        StFail:  error_d = 1'b1;
        StIdle:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StHdrHi;
      ret_q      <= StHdrHi;
      n_q        <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      idle_q     <= '0;
      tx_data_q  <= '0;
      transmit_q <= 1'b0;
      boot_q     <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      idle_q     <= idle_d;
      tx_data_q  <= tx_data_d;
      transmit_q <= transmit_d;
      boot_q     <= boot_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign tx_data  = tx_data_q;
  assign transmit = transmit_q;
  assign ram_addr = addr_q;
  assign ram_data = data_q;
  assign ram_we   = (state_q == StWrite);
  assign booting  = boot_q;
  assign cpu_rst  = boot_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_frame_bootloader.sv
// Bench for frame_bootloader: instance a (ADDR_BITS=4, WORD_BYTES=1) and instance b
// (WORD_BYTES=4) share the receive stream; each has its own tx_done responder.
module tb_frame_bootloader;

`ifdef BOOT_CHECKSUM_EN
  localparam bit CkEn = 1'b1;
`else
  localparam bit CkEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       trigger = 1'b0;
  logic       tx_done_a = 1'b0;
  logic       tx_done_b = 1'b0;

  logic [7:0]  tx_data_a, tx_data_b;
  logic        transmit_a, transmit_b;
  logic [3:0]  ram_addr_a;
  logic [15:0] ram_addr_b;
  logic [7:0]  ram_data_a;
  logic [31:0] ram_data_b;
  logic        ram_we_a, ram_we_b;
  logic        booting_a, booting_b, cpu_rst_a, cpu_rst_b;
  logic        done_a, done_b, error_a, error_b;

  always #5 clk = ~clk;

  frame_bootloader #(.ADDR_BITS(4), .WORD_BYTES(1), .TIMEOUT_CYCLES(50)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done), .tx_done(tx_done_a),
    .tx_data(tx_data_a), .transmit(transmit_a), .ram_addr(ram_addr_a), .ram_data(ram_data_a),
    .ram_we(ram_we_a), .trigger(trigger), .booting(booting_a), .cpu_rst(cpu_rst_a),
    .done(done_a), .error(error_a)
  );

  frame_bootloader #(.ADDR_BITS(16), .WORD_BYTES(4), .TIMEOUT_CYCLES(50)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done), .tx_done(tx_done_b),
    .tx_data(tx_data_b), .transmit(transmit_b), .ram_addr(ram_addr_b), .ram_data(ram_data_b),
    .ram_we(ram_we_b), .trigger(trigger), .booting(booting_b), .cpu_rst(cpu_rst_b),
    .done(done_b), .error(error_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] echo_a[$];
  logic [31:0] wa_addr[$], wa_data[$], wb_addr[$], wb_data[$];
  int dly_a = 0;
  int dly_b = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  // Log echoes/writes and answer each transmit with tx_done three cycles later.
  always @(negedge clk) begin
    if (transmit_a) echo_a.push_back(32'(tx_data_a));
    if (ram_we_a) begin
      wa_addr.push_back(32'(ram_addr_a));
      wa_data.push_back(32'(ram_data_a));
    end
    if (ram_we_b) begin
      wb_addr.push_back(32'(ram_addr_b));
      wb_data.push_back(ram_data_b);
    end
    tx_done_a = (dly_a == 1);
    if (transmit_a) dly_a = 3;
    else if (dly_a != 0) dly_a--;
    tx_done_b = (dly_b == 1);
    if (transmit_b) dly_b = 3;
    else if (dly_b != 0) dly_b--;
  end

  task automatic clear_logs();
    echo_a.delete();
    wa_addr.delete();
    wa_data.delete();
    wb_addr.delete();
    wb_data.delete();
  endtask

  // Called on a negedge; returns on a negedge well after the echo has completed.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (7) @(negedge clk);
  endtask

  task automatic send_ck(input logic [7:0] s);
    if (CkEn) send_byte(s);
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    clear_logs();
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_echo [5];
    exp_echo = '{32'h00, 32'h02, 32'hAA, 32'h55, 32'hFF};

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_booting", 32'(booting_a), 32'd1);
    check_eq("rst_cpu_rst", 32'(cpu_rst_a), 32'd1);
    check_eq("rst_done_error", {30'd0, done_a, error_a}, 32'd0);
    check_eq("rst_tx_we", {30'd0, transmit_a, ram_we_a}, 32'd0);
    check_eq("rst_ram_addr_data", {20'd0, ram_addr_a, ram_data_a}, 32'd0);
    check_eq("rst_tx_data", 32'(tx_data_a), 32'd0);
    rst_n = 1'b1;

    // Two-word frame right after reset release
    send_byte(8'h00); send_byte(8'h02); send_byte(8'hAA); send_byte(8'h55); send_ck(8'hFF);
    repeat (3) @(negedge clk);
    check_eq("t1_echo_cnt", 32'(echo_a.size()), 32'(4 + int'(CkEn)));
    for (int i = 0; i < 4 + int'(CkEn); i++) check_eq("t1_echo", qget(echo_a, i), exp_echo[i]);
    check_eq("t1_we_cnt", 32'(wa_addr.size()), 32'd2);
    check_eq("t1_w0", {qget(wa_addr, 0)[15:0], qget(wa_data, 0)[15:0]}, 32'h0000_00AA);
    check_eq("t1_w1", {qget(wa_addr, 1)[15:0], qget(wa_data, 1)[15:0]}, 32'h0001_0055);
    check_eq("t1_done", 32'(done_a), 32'd1);
    check_eq("t1_cpu_rst", {30'd0, cpu_rst_a, booting_a}, 32'd0);
    check_eq("t1_error", 32'(error_a), 32'd0);

    // Four-byte words assemble LSB-first
    pulse_trigger();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_ck(8'hAA);
    repeat (3) @(negedge clk);
    check_eq("t2_we_cnt", 32'(wb_addr.size()), 32'd1);
    check_eq("t2_addr", qget(wb_addr, 0), 32'd0);
    check_eq("t2_data", qget(wb_data, 0), 32'h4433_2211);
    check_eq("t2_done", 32'(done_b), 32'd1);

    // N = 17 exceeds 2^4 words
    pulse_trigger();
    send_byte(8'h00); send_byte(8'h11);
    repeat (3) @(negedge clk);
    check_eq("t3_echo_cnt", 32'(echo_a.size()), 32'd2);
    check_eq("t3_echo1", qget(echo_a, 1), 32'h11);
    check_eq("t3_error", 32'(error_a), 32'd1);
    check_eq("t3_no_we", 32'(wa_addr.size()), 32'd0);
    check_eq("t3_held", {29'd0, booting_a, cpu_rst_a, done_a}, 32'b110);

    // N = 16 fills the whole space and the address wraps
    pulse_trigger();
    send_byte(8'h00); send_byte(8'h10);
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    send_ck(8'h78);
    repeat (3) @(negedge clk);
    check_eq("t4_we_cnt", 32'(wa_addr.size()), 32'd16);
    check_eq("t4_last", {qget(wa_addr, 15)[15:0], qget(wa_data, 15)[15:0]}, 32'h000F_000F);
    check_eq("t4_addr_wrap", 32'(ram_addr_a), 32'd0);
    check_eq("t4_done", {30'd0, done_a, error_a}, 32'b10);

    // N = 0 writes nothing
    pulse_trigger();
    send_byte(8'h00); send_byte(8'h00); send_ck(8'h00);
    repeat (3) @(negedge clk);
    check_eq("t5_no_we", 32'(wa_addr.size()), 32'd0);
    check_eq("t5_echo_cnt", 32'(echo_a.size()), 32'(2 + int'(CkEn)));
    check_eq("t5_done", {30'd0, done_a, error_a}, 32'b10);

    // Timeout after one data byte, then recovery by trigger
    pulse_trigger();
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h5A);
    repeat (40) @(negedge clk);
    check_eq("t6_no_early_err", 32'(error_a), 32'd0);
    repeat (10) @(negedge clk);
    check_eq("t6_timeout_err", 32'(error_a), 32'd1);
    pulse_trigger();
    check_eq("t6_retrig", {30'd0, error_a, booting_a}, 32'b01);
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h3C); send_byte(8'hC3); send_ck(8'hFF);
    repeat (3) @(negedge clk);
    check_eq("t6_w0", {qget(wa_addr, 0)[15:0], qget(wa_data, 0)[15:0]}, 32'h0000_003C);
    check_eq("t6_w1", {qget(wa_addr, 1)[15:0], qget(wa_data, 1)[15:0]}, 32'h0001_00C3);
    check_eq("t6_done", 32'(done_a), 32'd1);

    // Extra rx_done while echoing is dropped
    pulse_trigger();
    send_byte(8'h00); send_byte(8'h03);
    rx_data = 8'h11; rx_done = 1'b1;
    @(negedge clk);
    rx_data = 8'hEE;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (6) @(negedge clk);
    send_byte(8'h22); send_byte(8'h33); send_ck(8'h66);
    repeat (3) @(negedge clk);
    check_eq("t7_echo_cnt", 32'(echo_a.size()), 32'(5 + int'(CkEn)));
    check_eq("t7_echo2", qget(echo_a, 2), 32'h11);
    check_eq("t7_echo3", qget(echo_a, 3), 32'h22);
    check_eq("t7_we_cnt", 32'(wa_addr.size()), 32'd3);
    check_eq("t7_w1", {qget(wa_addr, 1)[15:0], qget(wa_data, 1)[15:0]}, 32'h0001_0022);
    check_eq("t7_done", 32'(done_a), 32'd1);

    // Reset while a data byte is being echoed
    pulse_trigger();
    send_byte(8'h00); send_byte(8'h02);
    rx_data = 8'h77; rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("t8_rst_addr", 32'(ram_addr_a), 32'd0);
    check_eq("t8_rst_flags", {28'd0, booting_a, transmit_a, ram_we_a, error_a}, 32'b1000);
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h99); send_ck(8'h99);
    repeat (3) @(negedge clk);
    check_eq("t8_we_cnt", 32'(wa_addr.size()), 32'd1);
    check_eq("t8_w0", {qget(wa_addr, 0)[15:0], qget(wa_data, 0)[15:0]}, 32'h0000_0099);
    check_eq("t8_done", 32'(done_a), 32'd1);
    check_eq("t8_b_no_partial", 32'(wb_addr.size()), 32'd0);

`ifdef BOOT_CHECKSUM_EN
    // Wrong checksum fails the boot
    pulse_trigger();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h10); send_byte(8'h11);
    repeat (3) @(negedge clk);
    check_eq("t9_echo_cnt", 32'(echo_a.size()), 32'd4);
    check_eq("t9_flags", {29'd0, done_a, error_a, cpu_rst_a}, 32'b011);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frame_bootloader.md
FRAME_BOOTLOADER -- requirements
Module: frame_bootloader

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 16: RAM word address width, 1..16.
REQ-002 SHALL have parameter WORD_BYTES, default 1: bytes per RAM word, 1..4.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000: idle cycles allowed between host bytes.
REQ-004 SHALL have ports clk in 1 (clock) and rst_n in 1 (asynchronous, active-low reset); one clock, reset asynchronous and active-low.
REQ-005 SHALL have ports rx_data in 8 (UART byte), rx_done in 1 (1-cycle byte-valid pulse), tx_done in 1 (1-cycle echo-complete pulse).
REQ-006 SHALL have ports tx_data out 8 (echo byte) and transmit out 1 (1-cycle send request).
REQ-007 SHALL have ports ram_addr out ADDR_BITS, ram_data out 8*WORD_BYTES, ram_we out 1 (1-cycle write strobe).
REQ-008 SHALL have ports trigger in 1 (start/restart boot), booting out 1, cpu_rst out 1, done out 1 (sticky success), error out 1 (sticky failure).

Function
REQ-009 SHALL implement states IDLE, HDR_HI, HDR_LO, RECV, ECHO, WRITE, CKSUM, FINISH, FAIL.
REQ-010 SHALL, on trigger high in any state, next cycle enter HDR_HI with booting=1, cpu_rst=1, done=0, error=0, ram_addr=0, byte index=0, checksum=0; trigger takes priority over all other events.
REQ-011 SHALL take a 16-bit big-endian word count N from HDR_HI then HDR_LO bytes.
REQ-012 SHALL echo every accepted byte (header, data, checksum): tx_data<=rx_data and transmit=1 for exactly one cycle the cycle after rx_done, then wait in ECHO for tx_done before returning to the next receive state.
REQ-013 SHALL ignore rx_done while in ECHO (byte dropped, not echoed, not counted).
REQ-014 SHALL assemble data bytes LSB-first into ram_data; byte k of a word lands in bits [8k+7:8k].
REQ-015 SHALL, after the WORD_BYTES-th byte's echo completes, pulse ram_we for one cycle with stable ram_addr/ram_data, then increment ram_addr by 1.
REQ-016 SHALL go to FAIL after the header if N > 2^ADDR_BITS; N = 2^ADDR_BITS is legal and ram_addr wraps to 0 after the last write without effect.
REQ-017 SHALL, with N = 0, skip RECV/WRITE entirely (no ram_we) and proceed to CKSUM or FINISH.
REQ-018 SHALL, in any receive state (HDR_HI, HDR_LO, RECV, CKSUM), count idle cycles; reaching TIMEOUT_CYCLES without rx_done enters FAIL; counter clears on each accepted byte.
REQ-019 SHALL, in FINISH, set done=1, booting=0, cpu_rst=0, then hold in IDLE until trigger.
REQ-020 SHALL, in FAIL, set error=1, keep booting=1 and cpu_rst=1, and hold until trigger.
REQ-021 SHALL keep transmit and ram_we low in IDLE, FINISH, FAIL.

Reset
REQ-022 SHALL, while rst_n=0, force state=HDR_HI, booting=1, cpu_rst=1, done=0, error=0, transmit=0, ram_we=0, tx_data=0, ram_addr=0, ram_data=0, counters=0; boot begins automatically after reset release.
REQ-023 SHALL abandon any in-progress frame when rst_n asserts mid-transfer; no partial ram_we after release.

Configuration
REQ-024 SHALL, with BOOT_CHECKSUM_EN defined, accumulate an 8-bit modulo-256 sum of all data bytes and, after the last data word, receive and echo one checksum byte in CKSUM: equal -> FINISH, unequal -> FAIL.
REQ-025 SHALL, without BOOT_CHECKSUM_EN, omit CKSUM and the accumulator, going directly from last WRITE (or header with N=0) to FINISH.

Verification
REQ-026 WORD_BYTES=1: reset release, send 00 02 AA 55 (+checksum FF if enabled) -> four/five echoes, ram_we at addr 0 data AA, addr 1 data 55, done=1, cpu_rst=0.
REQ-027 WORD_BYTES=4: header 00 01, bytes 11 22 33 44 -> one ram_we, addr 0, ram_data=44332211.
REQ-028 BOOT_CHECKSUM_EN: header 00 01, data 10, checksum 11 -> echo of all bytes, no done, error=1, cpu_rst held 1.
REQ-029 ADDR_BITS=4: header 00 11 (N=17) -> echoes of both header bytes, then error=1, no ram_we.
REQ-030 TIMEOUT_CYCLES=50: header 00 02, one data byte, then silence -> error=1 at 50 idle cycles; then trigger -> error=0, booting=1, fresh frame loads correctly.
REQ-031 Extra rx_done pulse during ECHO, and rst_n low mid-data -> extra byte not echoed/written; after reset, frame restarts with ram_addr=0.
